trn_sync_bus: RTL and testbench

TRN_SYNC_BUS -- requirements
Module: trn_sync_bus

---
 rtl/trn_sync_bus.sv | 82 ++++++++
 tb/tb_trn_sync_bus.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trn_sync_bus.sv
// Multi-bit synchroniser for a status bus crossing from the trn domain into sys_clk.
// A word is accepted only after it has been seen unchanged for STABLE consecutive cycles.
module trn_sync_bus #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int STABLE = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] trn__stat_async,
  input  logic             freeze,
  output logic [WIDTH-1:0] sys__stat,
  output logic             sys__stat_valid,
  output logic             sys__stat_upd,
  output logic [15:0]      sys__upd_cnt
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE);

  logic [WIDTH-1:0]  sync_q [STAGES];
  logic [STAGES-1:0] fill_q;
  logic [WIDTH-1:0]  s;
  logic              s_vld;
  logic [WIDTH-1:0]  cand;
  logic              cand_vld;
  logic [7:0]        cnt;
  logic              accept;

  assign s     = sync_q[STAGES-1];
  assign s_vld = fill_q[STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= trn__stat_async;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
    end
  end

  // fill_q tracks which stages hold post-reset samples, so the cleared pipeline
  // contents never count toward stability (a steady 0 still needs the full latency).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cand     <= '0;
      cand_vld <= 1'b0;
      cnt      <= '0;
    end else begin
      cand     <= s;
      cand_vld <= s_vld;
      if (!s_vld)
        cnt <= '0;
      else if (!cand_vld || (s != cand))
        cnt <= 8'd1;
      else if (cnt != STABLE_CNT)
        cnt <= cnt + 8'd1;
    end
  end

  assign accept = (cnt == STABLE_CNT) && !freeze &&
                  ((cand != sys__stat) || !sys__stat_valid);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sys__stat       <= '0;
      sys__stat_valid <= 1'b0;
      sys__stat_upd   <= 1'b0;
      sys__upd_cnt    <= '0;
    end else begin
      sys__stat_upd <= accept;
      if (accept) begin
        sys__stat       <= cand;
        sys__stat_valid <= 1'b1;
        if (sys__upd_cnt != 16'hFFFF)
          sys__upd_cnt <= sys__upd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_trn_sync_bus.sv
// Scoreboard bench for trn_sync_bus: default-parameter instance for the functional
// scenarios and a fast-accepting 1-bit instance for the update-counter saturation.
module tb_trn_sync_bus;

  localparam int W = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          freeze;
  logic [W-1:0]  trn__stat_async;
  logic [W-1:0]  sys__stat;
  logic          sys__stat_valid;
  logic          sys__stat_upd;
  logic [15:0]   sys__upd_cnt;

  logic          sat_in;
  logic          sat_freeze;
  logic          sat_stat;
  logic          sat_valid;
  logic          sat_upd;
  logic [15:0]   sat_cnt;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q [$];

  always #5 sys_clk = ~sys_clk;

  trn_sync_bus dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .trn__stat_async (trn__stat_async),
    .freeze          (freeze),
    .sys__stat       (sys__stat),
    .sys__stat_valid (sys__stat_valid),
    .sys__stat_upd   (sys__stat_upd),
    .sys__upd_cnt    (sys__upd_cnt)
  );

  trn_sync_bus #(.WIDTH(1), .STAGES(2), .STABLE(1)) u_sat (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .trn__stat_async (sat_in),
    .freeze          (sat_freeze),
    .sys__stat       (sat_stat),
    .sys__stat_valid (sat_valid),
    .sys__stat_upd   (sat_upd),
    .sys__upd_cnt    (sat_cnt)
  );

  // every update pulse must match the next expected word
  always @(negedge sys_clk) begin
    if (!sys_rst && sys__stat_upd === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_upd: got stat=%h want no update", sys__stat);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (sys__stat !== e) begin
          bad++;
          $display("FAIL sb_stat: got %h want %h", sys__stat, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic enter_reset();
    sys_rst = 1'b1;
    freeze  = 1'b0;
    tick(2);
    exp_q.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    freeze = 1'b1;
    trn__stat_async = 32'h1234_5678;
    tick(3);
    total++;
    if ({sys__stat, sys__stat_valid, sys__stat_upd} !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_out: got stat=%h valid=%b upd=%b want 0 0 0",
               sys__stat, sys__stat_valid, sys__stat_upd);
    end
    total++;
    if (sys__upd_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_cnt: got %h want 0000", sys__upd_cnt);
    end
  endtask

  task automatic test_basic();
    enter_reset();
    trn__stat_async = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    sys_rst = 1'b0;
    tick(5);
    total++;
    if ({sys__stat_valid, sys__stat_upd} !== 2'b00) begin
      bad++;
      $display("FAIL basic_early: got valid=%b upd=%b want 0 0", sys__stat_valid, sys__stat_upd);
    end
    tick(1);
    total++;
    if ({sys__stat, sys__stat_valid, sys__stat_upd} !== {32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL basic_edge6: got stat=%h valid=%b upd=%b want deadbeef 1 1",
               sys__stat, sys__stat_valid, sys__stat_upd);
    end
    tick(1);
    total++;
    if (sys__stat_upd !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: got upd=%b want 0", sys__stat_upd);
    end
    tick(10);
    total++;
    if (sys__upd_cnt !== 16'd1) begin
      bad++;
      $display("FAIL basic_cnt: got %0d want 1", sys__upd_cnt);
    end
  endtask

  task automatic test_zero();
    enter_reset();
    trn__stat_async = 32'h0;
    exp_q.push_back(32'h0);
    sys_rst = 1'b0;
    tick(5);
    total++;
    if ({sys__stat_valid, sys__stat_upd} !== 2'b00) begin
      bad++;
      $display("FAIL zero_early: got valid=%b upd=%b want 0 0", sys__stat_valid, sys__stat_upd);
    end
    tick(1);
    total++;
    if ({sys__stat, sys__stat_valid, sys__stat_upd} !== {32'h0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL zero_edge6: got stat=%h valid=%b upd=%b want 0 1 1",
               sys__stat, sys__stat_valid, sys__stat_upd);
    end
    tick(20);
    total++;
    if (sys__upd_cnt !== 16'd1) begin
      bad++;
      $display("FAIL zero_cnt: got %0d want 1", sys__upd_cnt);
    end
  endtask

  task automatic test_glitch();
    int ups;
    enter_reset();
    sys_rst = 1'b0;
    ups = 0;
    for (int c = 0; c < 40; c++) begin
      trn__stat_async = (((c / 2) % 2) == 0) ? 32'h2 : 32'h1;
      tick(1);
      if (sys__stat_upd === 1'b1) ups++;
    end
    total++;
    if (ups != 0 || sys__stat_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_toggle: got ups=%0d valid=%b want 0 0", ups, sys__stat_valid);
    end
    trn__stat_async = 32'h2;
    exp_q.push_back(32'h2);
    ups = 0;
    for (int h = 1; h <= 5; h++) begin
      tick(1);
      if (sys__stat_upd === 1'b1) ups++;
    end
    total++;
    if (ups != 0) begin
      bad++;
      $display("FAIL glitch_hold_early: got ups=%0d want 0", ups);
    end
    tick(1);
    total++;
    if ({sys__stat, sys__stat_upd} !== {32'h2, 1'b1}) begin
      bad++;
      $display("FAIL glitch_hold6: got stat=%h upd=%b want 2 1", sys__stat, sys__stat_upd);
    end
    tick(10);
    total++;
    if (sys__upd_cnt !== 16'd1) begin
      bad++;
      $display("FAIL glitch_cnt: got %0d want 1", sys__upd_cnt);
    end
  endtask

  task automatic test_skew();
    int ups;
    enter_reset();
    trn__stat_async = 32'h0;
    exp_q.push_back(32'h0);
    sys_rst = 1'b0;
    tick(10);
    exp_q.push_back(32'hFF);
    ups = 0;
    trn__stat_async = 32'h0F;
    tick(1);
    if (sys__stat_upd === 1'b1) ups++;
    trn__stat_async = 32'hFF;
    repeat (14) begin
      tick(1);
      if (sys__stat_upd === 1'b1) ups++;
    end
    total++;
    if (ups != 1 || sys__stat !== 32'hFF) begin
      bad++;
      $display("FAIL skew: got ups=%0d stat=%h want 1 000000ff", ups, sys__stat);
    end
  endtask

  task automatic test_freeze();
    int ups;
    enter_reset();
    trn__stat_async = 32'h5;
    exp_q.push_back(32'h5);
    sys_rst = 1'b0;
    tick(8);
    freeze = 1'b1;
    trn__stat_async = 32'hA;
    exp_q.push_back(32'hA);
    ups = 0;
    repeat (20) begin
      tick(1);
      if (sys__stat_upd === 1'b1) ups++;
    end
    total++;
    if (ups != 0 || sys__stat !== 32'h5) begin
      bad++;
      $display("FAIL freeze_hold: got ups=%0d stat=%h want 0 5", ups, sys__stat);
    end
    freeze = 1'b0;
    tick(1);
    total++;
    if ({sys__stat, sys__stat_upd} !== {32'hA, 1'b1}) begin
      bad++;
      $display("FAIL freeze_release: got stat=%h upd=%b want a 1", sys__stat, sys__stat_upd);
    end
  endtask

  task automatic test_reset_mid();
    int ups;
    enter_reset();
    trn__stat_async = 32'h77;
    exp_q.push_back(32'h77);
    sys_rst = 1'b0;
    tick(8);
    trn__stat_async = 32'h33;
    tick(3);
    sys_rst = 1'b1;
    tick(1);
    total++;
    if ({sys__stat, sys__stat_valid, sys__stat_upd, sys__upd_cnt} !== {32'h0, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL rstmid_clear: got stat=%h valid=%b upd=%b cnt=%h want 0 0 0 0",
               sys__stat, sys__stat_valid, sys__stat_upd, sys__upd_cnt);
    end
    sys_rst = 1'b0;
    exp_q.push_back(32'h33);
    ups = 0;
    repeat (5) begin
      tick(1);
      if (sys__stat_upd === 1'b1) ups++;
    end
    total++;
    if (ups != 0) begin
      bad++;
      $display("FAIL rstmid_early: got ups=%0d want 0", ups);
    end
    tick(1);
    total++;
    if ({sys__stat, sys__stat_upd} !== {32'h33, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_edge6: got stat=%h upd=%b want 33 1", sys__stat, sys__stat_upd);
    end
  endtask

  task automatic test_sat();
    int n;
    enter_reset();
    sat_in = 1'b0;
    exp_q.push_back(trn__stat_async);
    sys_rst = 1'b0;
    n = 0;
    while (sat_cnt != 16'hFFFE && n < 70000) begin
      sat_in = ~sat_in;
      tick(1);
      n++;
    end
    total++;
    if (sat_cnt !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_reach: got %h want fffe after %0d cycles", sat_cnt, n);
    end
    repeat (2) begin
      sat_in = ~sat_in;
      tick(1);
    end
    total++;
    if (sat_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_top: got %h want ffff", sat_cnt);
    end
    repeat (10) begin
      sat_in = ~sat_in;
      tick(1);
    end
    total++;
    if ({sat_cnt, sat_upd} !== {16'hFFFF, 1'b1}) begin
      bad++;
      $display("FAIL sat_hold: got cnt=%h upd=%b want ffff 1", sat_cnt, sat_upd);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    freeze = 1'b0;
    trn__stat_async = '0;
    sat_in = 1'b0;
    sat_freeze = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_glitch();
    test_skew();
    test_freeze();
    test_reset_mid();
    test_sat();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
